// File: rtl/board_ram_arbiter_pkg.sv
// Shared board definitions: default RAM geometry, arbiter FSM states and
// the port identifiers used by the round-robin pointer.
package board_ram_arbiter_pkg;

  // 8x8 board, 2-bit cell state.
  localparam int BOARD_ADDR_W = 6;
  localparam int BOARD_DATA_W = 2;

  // Arbiter FSM: normal two-port service, or the full-board clear sweep.
  typedef enum logic {
    S_SERVE = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Identity of the most recently granted port.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/board_ram_arbiter_clear_seq.sv
// Clear sweep address counter. Loaded to 0 when a sweep starts, advances one
// cell per cycle while the arbiter is clearing, and flags the last cell so the
// arbiter can leave the clear state. The counter wraps to 0 by itself.
module board_clear_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next counter value: restart on a new sweep, step while sweeping.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = cnt_q;
  assign done = busy && (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares one synchronous-read RAM between the game logic
// (port A, read/write) and the display scan (port B, read-only) with
// round-robin arbitration, and can sweep the whole board to zero on request.
module board_ram_arbiter
  import board_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int DATA_W = BOARD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   a_rvalid_q, b_rvalid_q;
  logic   clr_done_q;

  logic              seq_start;
  logic              seq_done;
  logic [ADDR_W-1:0] seq_addr;

  // A sweep only starts from normal service; a request mid-sweep is dropped.
  assign seq_start = (state_q == S_SERVE) && clr_start;
  assign clr_busy  = (state_q == S_CLEAR);

  board_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk   (clk),
    .rst   (rst),
    .start (seq_start),
    .busy  (clr_busy),
    .addr  (seq_addr),
    .done  (seq_done)
  );

  // Arbitration, RAM port steering and next-state selection.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      S_SERVE: begin
        // A wins when alone, or on contention if B was granted last.
        if (a_req && (!b_req || last_q == PORT_B)) begin
          a_gnt     = 1'b1;
          ram_we    = a_we;
          ram_addr  = a_addr;
          ram_wdata = a_wdata;
          last_d    = PORT_A;
        end else if (b_req) begin
          b_gnt    = 1'b1;
          ram_addr = b_addr;
          last_d   = PORT_B;
        end
        if (clr_start) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = seq_addr;
        if (seq_done) begin
          state_d = S_SERVE;
        end
      end
      default: state_d = S_SERVE;
    endcase
  end

  // State, arbitration pointer, read-valid and clear-done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SERVE;
      last_q     <= PORT_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt;
      clr_done_q <= seq_done;
    end
  end

  // Read data comes straight from the RAM; rvalid qualifies it per port.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural 64x2 RAM.
module tb_board_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start;
  logic       clr_busy, clr_done;
  logic       a_req, a_we;
  logic [5:0] a_addr;
  logic [1:0] a_wdata;
  logic       a_gnt, a_rvalid;
  logic [1:0] a_rdata;
  logic       b_req;
  logic [5:0] b_addr;
  logic       b_gnt, b_rvalid;
  logic [1:0] b_rdata;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] tb_ram [64];

  always #5 clk = ~clk;

  // Synchronous RAM, 1-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr];
  end

  board_ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a sweep and follow it cycle by cycle. Optionally re-pulse
  // clr_start or assert rst at a given sweep cycle. n = cycles spent busy.
  task automatic sweep(input logic exp_b, input logic [1:0] exp_bdata,
                       input int poke_at, input int rst_at, output int n);
    clr_start = 1'b1;
    #1;
    chk("start_idle_busy", clr_busy, 1'b0);
    if (exp_b) chk("start_b_gnt", b_gnt, 1'b1);
    tick();
    clr_start = 1'b0;
    b_req     = 1'b0;
    #1;
    chk("first_clear_b_rvalid", b_rvalid, exp_b);
    if (exp_b) chk("first_clear_b_rdata", b_rdata, exp_bdata);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!clr_busy) break;
      chk("sweep_addr", ram_addr, i[5:0]);
      chk("sweep_we", ram_we, 1'b1);
      chk("sweep_wdata", ram_wdata, 2'd0);
      chk("sweep_no_gnt", {a_gnt, b_gnt}, 2'b00);
      chk("sweep_no_done", clr_done, 1'b0);
      if (i == poke_at) clr_start = 1'b1;
      if (i == rst_at) rst = 1'b1;
      n++;
      tick();
      clr_start = 1'b0;
      rst       = 1'b0;
      #1;
    end
  endtask

  initial begin
    int n;
    int nonzero;
    rst = 1'b1; clr_start = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;
    for (int i = 0; i < 64; i++) tb_ram[i] = 2'd3;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", clr_busy, 1'b0);
    chk("rst_done", clr_done, 1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("idle_gnt", {a_gnt, b_gnt}, 2'b00);

    // Contention from reset: A first, then alternate.
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_addr = 6'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_a_gnt", a_gnt, (k % 2 == 0));
      chk("rr_b_gnt", b_gnt, (k % 2 == 1));
      chk("rr_read_we", ram_we, 1'b0);
      tick();
      chk("rr_a_rvalid", a_rvalid, (k % 2 == 0));
      chk("rr_b_rvalid", b_rvalid, (k % 2 == 1));
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("rr_rvalid_drop", {a_rvalid, b_rvalid}, 2'b00);

    // A write of 2 to addr 5, then A read of addr 5.
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 2'd2;
    #1;
    chk("wr_a_gnt", a_gnt, 1'b1);
    chk("wr_b_gnt", b_gnt, 1'b0);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 6'd5);
    chk("wr_ram_wdata", ram_wdata, 2'd2);
    tick();
    a_we = 1'b0;
    #1;
    chk("wr_no_rvalid", a_rvalid, 1'b0);
    chk("rd_ram_we", ram_we, 1'b0);
    chk("rd_ram_addr", ram_addr, 6'd5);
    tick();
    a_req = 1'b0;
    chk("rd_a_rvalid", a_rvalid, 1'b1);
    chk("rd_a_rdata", a_rdata, 2'd2);
    tick();
    chk("rd_rvalid_one_cycle", a_rvalid, 1'b0);

    // Prefill every cell with 1.
    a_req = 1'b1; a_we = 1'b1; a_wdata = 2'd1;
    for (int i = 0; i < 64; i++) begin
      a_addr = i[5:0];
      tick();
    end
    a_we = 1'b0; a_addr = 6'd7;

    // Clear with a concurrent B read of addr 10; A (last granted) loses and
    // then holds its read request across the sweep.
    b_req = 1'b1; b_addr = 6'd10;
    sweep(1'b1, 2'd1, -1, -1, n);
    chk("sweep1_cycles", n, 64);
    chk("sweep1_done", clr_done, 1'b1);
    chk("sweep1_a_served", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk("sweep1_done_pulse", clr_done, 1'b0);
    chk("held_a_rvalid", a_rvalid, 1'b1);
    chk("held_a_rdata", a_rdata, 2'd0);
    nonzero = 0;
    for (int i = 0; i < 64; i++) if (tb_ram[i] != 2'd0) nonzero++;
    chk("ram_cleared", nonzero, 0);

    // B reads of addr 0 and 63 return 0.
    b_req = 1'b1; b_addr = 6'd0;
    tick();
    b_addr = 6'd63;
    chk("b_rd0_valid", b_rvalid, 1'b1);
    chk("b_rd0_data", b_rdata, 2'd0);
    tick();
    b_req = 1'b0;
    chk("b_rd63_valid", b_rvalid, 1'b1);
    chk("b_rd63_data", b_rdata, 2'd0);
    tick();

    // Re-pulse of clr_start at sweep cycle 30 is ignored.
    sweep(1'b0, 2'd0, 30, -1, n);
    chk("repoke_cycles", n, 64);
    chk("repoke_done", clr_done, 1'b1);
    tick();
    chk("repoke_single_done", clr_done, 1'b0);
    chk("repoke_no_restart", clr_busy, 1'b0);

    // Reset at sweep cycle 20 aborts without clr_done.
    sweep(1'b0, 2'd0, -1, 20, n);
    chk("abort_cycles", n, 21);
    chk("abort_busy", clr_busy, 1'b0);
    chk("abort_no_done", clr_done, 1'b0);
    tick();
    chk("abort_no_done_late", clr_done, 1'b0);

    // A fresh sweep after the abort starts from address 0.
    sweep(1'b0, 2'd0, -1, -1, n);
    chk("after_abort_cycles", n, 64);
    chk("after_abort_done", clr_done, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/board_ram_arbiter.md
BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the board RAM address width (64 cells).
REQ-002 The block SHALL have parameter DATA_W, default 2, meaning the cell state width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port clr_start, input, 1: a pulse that requests a full board clear.
REQ-006 The block SHALL have port clr_busy, output, 1: high while the clear sweep runs.
REQ-007 The block SHALL have port clr_done, output, 1: a one-cycle pulse after the clear completes.
REQ-008 The block SHALL have the game-logic port A signals a_req (in, 1), a_we (in, 1), a_addr (in, ADDR_W), a_wdata (in, DATA_W), a_gnt (out, 1), a_rvalid (out, 1) and a_rdata (out, DATA_W).
REQ-009 The block SHALL have the display-scan port B signals b_req (in, 1), b_addr (in, ADDR_W), b_gnt (out, 1), b_rvalid (out, 1) and b_rdata (out, DATA_W); port B is read-only.
REQ-010 The block SHALL have the RAM port signals ram_we (out, 1), ram_addr (out, ADDR_W), ram_wdata (out, DATA_W) and ram_rdata (in, DATA_W); the RAM has synchronous read with 1-cycle latency.

Function
REQ-011 The FSM SHALL have two states, S_SERVE and S_CLEAR.
REQ-012 In S_SERVE, a transfer SHALL be accepted in the cycle where req && gnt; gnt is combinational from req and the arbitration state, in the same cycle.
REQ-013 At most one of a_gnt and b_gnt SHALL be high in any cycle; gnt is never high without its req.
REQ-014 Arbitration SHALL be round-robin: with a single requester, that requester is granted; on contention, the port not granted most recently is granted.
REQ-015 The last-granted pointer SHALL update only on an accepted transfer.
REQ-016 On an accepted transfer, ram_addr, ram_we and ram_wdata SHALL be driven from the granted port in the same cycle; ram_we = a_we for port A, 0 for port B.
REQ-017 With no accepted transfer in S_SERVE, ram_we SHALL be 0; ram_addr and ram_wdata are don't-care.
REQ-018 An accepted read SHALL produce x_rvalid high for exactly one cycle, one cycle after acceptance, with x_rdata = ram_rdata.
REQ-019 An accepted write SHALL produce no rvalid.
REQ-020 A clr_start seen in S_SERVE SHALL move the FSM to S_CLEAR on the next edge; a transfer accepted in that same cycle completes normally.
REQ-021 In S_CLEAR, both gnt outputs SHALL be 0, ram_we = 1, ram_wdata = 0, and ram_addr = the sweep counter, stepping 0..63 one per cycle (64 cycles total).
REQ-022 When the counter reaches 63, the FSM SHALL return to S_SERVE and the counter SHALL wrap to 0.
REQ-023 clr_done SHALL pulse in the first S_SERVE cycle after the sweep.
REQ-024 clr_busy SHALL equal (state == S_CLEAR).
REQ-025 clr_start asserted while in S_CLEAR SHALL be ignored; it is neither queued nor restarts the sweep.
REQ-026 An rvalid owed from a read accepted in the last S_SERVE cycle SHALL still be delivered in the first S_CLEAR cycle.
REQ-027 Requests held during S_CLEAR SHALL be served, under normal arbitration, from the first S_SERVE cycle.

Reset
REQ-028 On rst, the block SHALL enter state S_SERVE, with the counter at 0 and the last-granted pointer at B, so A wins the first contention.
REQ-029 On rst, a_rvalid, b_rvalid, clr_busy and clr_done SHALL be 0 and ram_we SHALL be 0.
REQ-030 A rst during S_CLEAR SHALL abort the sweep without a clr_done pulse; a pending rvalid is dropped.

Structure
REQ-031 ADDR_W/DATA_W defaults, the FSM state encoding (S_SERVE, S_CLEAR) and the port-index constants (PORT_A, PORT_B) SHALL live in the shared board package.
REQ-032 The clear sweep counter and its done logic SHALL be one sub-module, board_clear_seq, with ports clk, rst, start, busy, addr and done.
REQ-033 The round-robin selection SHALL remain inline in board_ram_arbiter.

Verification
REQ-034 A-only write (addr 5, data 2), then A read of addr 5 -> ram_we=1 in the accept cycle; on the read, a_rvalid=1 and a_rdata=2 one cycle later.
REQ-035 A and B both request for 4 cycles -> grants alternate A, B, A, B; never both high.
REQ-036 clr_start with RAM prefilled with 1s -> clr_busy for 64 cycles, addresses 0..63 written with 0, clr_done pulses once; B reads of addr 0 and addr 63 afterwards return 0.
REQ-037 clr_start in the same cycle as an accepted B read -> b_rvalid arrives during the first S_CLEAR cycle, and the sweep still writes all 64 addresses.
REQ-038 clr_start pulsed again at sweep cycle 30 -> there is no restart, the sweep ends at cycle 64, and there is a single clr_done.
REQ-039 rst asserted at sweep cycle 20 -> the block is in S_SERVE next cycle, there is no clr_done, and a following clr_start sweeps from address 0.
